// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. It serves MULT/MULTU/DIV/DIVU and MTHI/MTLO.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        launch the operation selected by op (sampled only when idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   mthi, mtlo   write wdata to hi / lo (ignored while busy)
//   wdata        data for mthi / mtlo
//   busy         operation in progress
//   done         one-cycle pulse, hi/lo hold the result
//   div_by_zero  one-cycle pulse with done when a divide had divisor 0
//   hi, lo       HI / LO registers
//
// Timing: start at edge E0, WIDTH RUN cycles (one bit each), one FIX cycle
// that applies the sign correction; hi/lo and done update at E(WIDTH+1).
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement negate when neg is set; used for magnitudes and
    // for the final sign correction of quotient and remainder.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    state_t           state_r;
    logic             is_div_r;
    logic             neg_res_r;   // product/quotient must be negated
    logic             neg_dvd_r;   // dividend was negative (remainder sign)
    logic             b_zero_r;    // divide with zero divisor
    logic [WIDTH-1:0] opd_r;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_r;    // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo_r;    // multiplier shifting out / quotient shifting in
    logic [CW-1:0]    cnt_r;

    logic             signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    // Operand sign decode and magnitudes (op[0]=1 selects unsigned).
    always_comb begin
        signed_s = ~op[0];
        a_neg_s  = signed_s & a[WIDTH-1];
        b_neg_s  = signed_s & b[WIDTH-1];
        a_mag_s  = cond_neg(a, a_neg_s);
        b_mag_s  = cond_neg(b, b_neg_s);
    end

    // One iteration of shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} +
                      (acc_lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        // Remainder < divisor, so bit WIDTH of the difference is a clean borrow.
        div_diff_s  = div_shift_s - {1'b0, opd_r};
        if (is_div_r) begin
            if (!div_diff_s[WIDTH]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction applied in the FIX cycle.
    always_comb begin
        prod_s     = {acc_hi_r, acc_lo_r};
        prod_fix_s = neg_res_r ? (~prod_s + ONE_2W) : prod_s;
        quo_fix_s  = cond_neg(acc_lo_r, neg_res_r);
        rem_fix_s  = cond_neg(acc_hi_r, neg_dvd_r);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            is_div_r    <= 1'b0;
            neg_res_r   <= 1'b0;
            neg_dvd_r   <= 1'b0;
            b_zero_r    <= 1'b0;
            opd_r       <= {WIDTH{1'b0}};
            acc_hi_r    <= {WIDTH{1'b0}};
            acc_lo_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mthi) begin
                        hi <= wdata;
                    end else begin
                        hi <= hi;
                    end
                    if (mtlo) begin
                        lo <= wdata;
                    end else begin
                        lo <= lo;
                    end
                    if (start) begin
                        state_r   <= RUN;
                        busy      <= 1'b1;
                        is_div_r  <= op[1];
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_dvd_r <= a_neg_s;
                        b_zero_r  <= op[1] & (b == {WIDTH{1'b0}});
                        acc_hi_r  <= {WIDTH{1'b0}};
                        cnt_r     <= CW'(WIDTH);
                        // Divide shifts the dividend out of acc_lo; multiply
                        // shifts the multiplier out of it.
                        if (op[1]) begin
                            acc_lo_r <= a_mag_s;
                            opd_r    <= b_mag_s;
                        end else begin
                            acc_lo_r <= b_mag_s;
                            opd_r    <= a_mag_s;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (!is_div_r) begin
                        hi <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo <= prod_fix_s[WIDTH-1:0];
                    end else if (b_zero_r) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix_s;
                        lo <= quo_fix_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: one WIDTH=32 and one WIDTH=8
// instance. Issuing an operation pushes its expected hi/lo/div_by_zero and
// start cycle; monitors pop and compare on every done pulse.
module tb_mips_cpu_muldiv;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          c0;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        start32 = 1'b0, mthi32 = 1'b0, mtlo32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = 32'h0, b32 = 32'h0, wd32 = 32'h0;
    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;

    logic        start8 = 1'b0, mthi8 = 1'b0, mtlo8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = 8'h0, b8 = 8'h0, wd8 = 8'h0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    exp_t q32[$];
    exp_t q8[$];
    int   run32 = 0;
    int   run8 = 0;

    mips_cpu_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .mthi(mthi32), .mtlo(mtlo32), .wdata(wd32), .busy(busy32), .done(done32),
        .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    mips_cpu_muldiv #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .mthi(mthi8), .mtlo(mtlo8), .wdata(wd8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                chk("done32_unexpected", 32'd1, 32'd0);
            end else begin
                e = q32.pop_front();
                chk("hi32", hi32, e.hi);
                chk("lo32", lo32, e.lo);
                chk("dbz32", {31'b0, dbz32}, {31'b0, e.dbz});
                chk("lat32", 32'(cyc - e.c0), 32'd33);
                chk("busy32_len", 32'(run32), 32'd33);
            end
            run32 = 0;
        end else begin
            if (dbz32) chk("dbz32_without_done", 32'd1, 32'd0);
            if (busy32) run32++;
            else run32 = 0;
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("hi8", {24'h0, hi8}, e.hi);
                chk("lo8", {24'h0, lo8}, e.lo);
                chk("dbz8", {31'b0, dbz8}, {31'b0, e.dbz});
                chk("lat8", 32'(cyc - e.c0), 32'd9);
                chk("busy8_len", 32'(run8), 32'd9);
            end
            run8 = 0;
        end else begin
            if (busy8) run8++;
            else run8 = 0;
        end
    end

    // Wait (bounded) until the 32-bit unit is idle, then launch an operation,
    // optionally with mthi/mtlo in the same cycle.
    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic whi, input logic wlo, input logic [31:0] wd,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                           input bit push);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout_idle32", 32'd1, 32'd0);
        op32 = op; a32 = a; b32 = b; mthi32 = whi; mtlo32 = wlo; wd32 = wd;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        e.hi = ehi; e.lo = elo; e.dbz = edbz; e.c0 = cyc;
        if (push) q32.push_back(e);
        start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout_idle8", 32'd1, 32'd0);
        op8 = op; a8 = a; b8 = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        e.hi = {24'h0, ehi}; e.lo = {24'h0, elo}; e.dbz = 1'b0; e.c0 = cyc;
        q8.push_back(e);
        start8 = 1'b0;
    endtask

    // Bounded wait until both scoreboards are drained and units idle.
    task automatic drain;
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0 || busy32 || busy8) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("timeout_drain", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // Single-cycle mthi/mtlo write while idle.
    task automatic move32(input logic whi, input logic wlo, input logic [31:0] wd);
        @(negedge clk);
        mthi32 = whi; mtlo32 = wlo; wd32 = wd;
        @(posedge clk);
        #1;
        mthi32 = 1'b0; mtlo32 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi32, 32'h0);
        chk("rst_lo", lo32, 32'h0);
        chk("rst_busy", {31'b0, busy32}, 32'd0);
        chk("rst_done", {31'b0, done32}, 32'd0);
        chk("rst_dbz", {31'b0, dbz32}, 32'd0);

        // Arithmetic: consecutive issues start in the previous done cycle.
        issue32(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
        issue32(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0, 32'h00000002, 32'h0000000E, 1'b0, 1'b1);
        issue32(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
        issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
        drain();

        // mthi / mtlo, then divide by zero leaves them untouched.
        move32(1'b1, 1'b0, 32'h1234);
        @(negedge clk);
        chk("mthi_hi", hi32, 32'h1234);
        move32(1'b0, 1'b1, 32'h5678);
        @(negedge clk);
        chk("mtlo_lo", lo32, 32'h5678);
        chk("mtlo_hi_kept", hi32, 32'h1234);
        issue32(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h5678, 1'b1, 1'b1);
        // Both moves with start: divide by zero keeps the moved values.
        issue32(2'b11, 32'd9, 32'd0, 1'b1, 1'b1, 32'hABCD, 32'hABCD, 32'hABCD, 1'b1, 1'b1);
        // mthi with start: the product overwrites it.
        issue32(2'b01, 32'd2, 32'd3, 1'b1, 1'b0, 32'h1111, 32'h0, 32'h6, 1'b0, 1'b1);
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
        issue32(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b1);
        issue32(2'b11, 32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b1);
        issue32(2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1E, 1'b0, 1'b1);

        // Mid-operation start and mtlo are ignored.
        issue32(2'b01, 32'h10000, 32'h10000, 1'b0, 1'b0, 32'h0, 32'h1, 32'h0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        op32 = 2'b10; a32 = 32'd1; b32 = 32'd0; wd32 = 32'hDEAD;
        start32 = 1'b1; mtlo32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; mtlo32 = 1'b0;
        chk("midop_lo_kept", lo32, 32'h1E);
        chk("midop_busy", {31'b0, busy32}, 32'd1);

        // Back-to-back pair.
        issue32(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0, 32'h0, 32'd12, 1'b0, 1'b1);
        issue32(2'b11, 32'd12, 32'd5, 1'b0, 1'b0, 32'h0, 32'd2, 32'd2, 1'b0, 1'b1);
        drain();

        // Reset mid-operation: no done, result discarded.
        issue32(2'b01, 32'd3, 32'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_hi", hi32, 32'h0);
        chk("abort_lo", lo32, 32'h0);
        chk("abort_busy", {31'b0, busy32}, 32'd0);
        chk("abort_done", {31'b0, done32}, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_lo_after", lo32, 32'h0);

        // WIDTH=8 instance.
        issue8(2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        issue8(2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
        issue8(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
        issue8(2'b11, 8'hFF, 8'h10, 8'h0F, 8'h0F);
        drain();

        chk("q32_empty", 32'(q32.size()), 32'd0);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
